// File: rtl/ball_motion_if.sv
// ball_motion_if: paddle/brick inputs and ball state outputs of the ball engine
interface ball_motion_if;
  logic       frame_tick;
  logic       serve;
  logic [9:0] paddle_x;
  logic       brick_hit_v;
  logic       brick_hit_h;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic       in_play;
  logic       miss;
  logic [3:0] lives;
  logic       game_over;
  modport master (
    output frame_tick, serve, paddle_x, brick_hit_v, brick_hit_h,
    input  ball_x, ball_y, in_play, miss, lives, game_over
  );
  modport slave (
    input  frame_tick, serve, paddle_x, brick_hit_v, brick_hit_h,
    output ball_x, ball_y, in_play, miss, lives, game_over
  );
endinterface

// File: rtl/ball_motion.sv
// ball_motion: per-frame ball motion, bounces, misses and lives; define BALL_ANGLE_EN for zone-based paddle angles
module ball_motion #(
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int BALL_SIZE = 7,
  parameter int PADDLE_W  = 100,
  parameter int PADDLE_Y  = 440,
  parameter int SPEED     = 4,
  parameter int LIVES     = 3,
  parameter int START_X   = 270
) (
  input logic clk,
  input logic reset,
  ball_motion_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;
  localparam logic signed [11:0] XMAX  = 12'(SCREEN_W - BALL_SIZE);
  localparam logic signed [11:0] YMISS = 12'(SCREEN_H - BALL_SIZE);
  localparam logic signed [11:0] PTOP  = 12'(PADDLE_Y - BALL_SIZE);
  localparam logic signed [11:0] PY    = 12'(PADDLE_Y);
  localparam logic signed [11:0] PW    = 12'(PADDLE_W);
  localparam logic signed [11:0] BS    = 12'(BALL_SIZE);
  localparam logic signed [11:0] RIDE  = 12'((PADDLE_W - BALL_SIZE) / 2);
  localparam logic signed [4:0]  SPD   = 5'(SPEED);
  state_t state, state_n;
  logic [9:0] x, y, x_n, y_n;
  logic signed [4:0] dx, dy, dx_n, dy_n, dxf, dyf;
  logic [3:0] lives, lives_n;
  logic miss, miss_n, lat_v, lat_h, lat_v_n, lat_h_n, hit_v, hit_h, hit;
  logic signed [11:0] sx, sy, px, nx, ny, ride;
`ifdef BALL_ANGLE_EN
  localparam logic signed [11:0] T1   = 12'(PADDLE_W / 3);
  localparam logic signed [11:0] T2   = 12'(2 * PADDLE_W / 3);
  localparam logic signed [4:0]  HSPD = 5'(SPEED / 2 == 0 ? 1 : SPEED / 2);
  logic signed [11:0] o;
  assign o = nx + 12'(BALL_SIZE / 2) - px;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      x     <= 10'(START_X);
      y     <= PTOP[9:0];
      dx    <= SPD;
      dy    <= -SPD;
      lives <= 4'(LIVES);
      miss  <= 1'b0;
      lat_v <= 1'b0;
      lat_h <= 1'b0;
    end else begin
      state <= state_n;
      x     <= x_n;
      y     <= y_n;
      dx    <= dx_n;
      dy    <= dy_n;
      lives <= lives_n;
      miss  <= miss_n;
      lat_v <= lat_v_n;
      lat_h <= lat_h_n;
    end
  end
  // Signed 12-bit math so positions past either edge compare correctly instead of wrapping
  always_comb begin
    sx      = $signed({2'b00, x});
    sy      = $signed({2'b00, y});
    px      = $signed({2'b00, bus.paddle_x});
    nx      = sx + 12'(dx);
    ny      = sy + 12'(dy);
    ride    = px + RIDE;
    hit_v   = lat_v | bus.brick_hit_v;
    hit_h   = lat_h | bus.brick_hit_h;
    dxf     = hit_h ? -dx : dx;
    dyf     = hit_v ? -dy : dy;
    hit     = dy > 5'sd0 && sy + BS <= PY && ny + BS >= PY && nx + BS > px && nx < px + PW;
    state_n = state;
    x_n     = x;
    y_n     = y;
    dx_n    = dx;
    dy_n    = dy;
    lives_n = lives;
    miss_n  = 1'b0;
    lat_v_n = 1'b0;
    lat_h_n = 1'b0;
    if (state == IDLE) begin
      if (bus.frame_tick) begin
        x_n = ride < 12'sd0 ? 10'd0 : ride > XMAX ? XMAX[9:0] : ride[9:0];
        y_n = PTOP[9:0];
      end
      if (bus.serve) begin
        state_n = PLAY;
        dx_n    = SPD;
        dy_n    = -SPD;
      end
    end else if (state == PLAY) begin
      lat_v_n = bus.frame_tick ? 1'b0 : hit_v;
      lat_h_n = bus.frame_tick ? 1'b0 : hit_h;
      if (bus.frame_tick) begin
        dx_n = dxf;
        dy_n = dyf;
        x_n  = nx[9:0];
        y_n  = ny[9:0];
        // Walls and paddle force the sign, overriding any brick flip on this tick
        if (nx <= 12'sd0) begin
          x_n  = 10'd0;
          dx_n = dxf[4] ? -dxf : dxf;
        end else if (nx >= XMAX) begin
          x_n  = XMAX[9:0];
          dx_n = dxf[4] ? dxf : -dxf;
        end
        if (ny <= 12'sd0) begin
          y_n  = 10'd0;
          dy_n = dyf[4] ? -dyf : dyf;
        end else if (hit) begin
          y_n  = PTOP[9:0];
          dy_n = dyf[4] ? dyf : -dyf;
`ifdef BALL_ANGLE_EN
          dx_n = o < T1 ? -SPD : o >= T2 ? SPD : dx_n[4] ? -HSPD : HSPD;
`endif
        end else if (ny >= YMISS) begin
          y_n     = y;
          miss_n  = 1'b1;
          lives_n = lives == 4'd0 ? 4'd0 : lives - 4'd1;
          state_n = lives <= 4'd1 ? OVER : IDLE;
        end
      end
    end
  end
  assign bus.ball_x    = x;
  assign bus.ball_y    = y;
  assign bus.in_play   = state == PLAY;
  assign bus.game_over = state == OVER;
  assign bus.miss      = miss;
  assign bus.lives     = lives;
endmodule

// File: tb/tb_ball_motion.sv
// tb_ball_motion: directed checks of ride, bounces, bricks, misses, game over and reset
module tb_ball_motion;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_err = 0;
`ifdef BALL_ANGLE_EN
  localparam int MID_X = 243;
`else
  localparam int MID_X = 241;
`endif
  ball_motion_if bus ();
  ball_motion dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step(input logic t, input logic v, input logic h, input logic s);
    @(negedge clk);
    bus.frame_tick  = t;
    bus.brick_hit_v = v;
    bus.brick_hit_h = h;
    bus.serve       = s;
    @(negedge clk);
    bus.frame_tick  = 1'b0;
    bus.brick_hit_v = 1'b0;
    bus.brick_hit_h = 1'b0;
    bus.serve       = 1'b0;
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic run_a(input logic [9:0] px_hit, input int exp_x);
    do_reset();
    bus.paddle_x = 10'd200;
    ticks(1);
    check("ride_x", 32'(bus.ball_x), 246);
    check("ride_y", 32'(bus.ball_y), 433);
    check("ride_in_play", 32'(bus.in_play), 0);
    check("ride_lives", 32'(bus.lives), 3);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("serve_in_play", 32'(bus.in_play), 1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("hold_x", 32'(bus.ball_x), 246);
    ticks(96);
    check("pre_wall_x", 32'(bus.ball_x), 630);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("rwall_x", 32'(bus.ball_x), 633);
    check("rwall_y", 32'(bus.ball_y), 45);
    ticks(1);
    check("rwall_dx", 32'(bus.ball_x), 629);
    check("brick_v_dy", 32'(bus.ball_y), 49);
    ticks(95);
    check("descend_y", 32'(bus.ball_y), 429);
    bus.paddle_x = px_hit;
    ticks(1);
    check("hit_y", 32'(bus.ball_y), 433);
    check("hit_x", 32'(bus.ball_x), 245);
    ticks(1);
    check("hit_dy", 32'(bus.ball_y), 429);
    check("hit_dx", 32'(bus.ball_x), 32'(exp_x));
  endtask
  task automatic run_to_miss(input int exp_lives);
    ticks(1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 400 && !bus.miss; i++) ticks(1);
    check("miss_pulse", 32'(bus.miss), 1);
    check("miss_lives", 32'(bus.lives), 32'(exp_lives));
    check("miss_in_play", 32'(bus.in_play), 0);
    check("miss_over", 32'(bus.game_over), 32'(exp_lives == 0));
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("miss_one_cycle", 32'(bus.miss), 0);
  endtask
  initial begin
    bus.frame_tick  = 1'b0;
    bus.serve       = 1'b0;
    bus.paddle_x    = 10'd0;
    bus.brick_hit_v = 1'b0;
    bus.brick_hit_h = 1'b0;
    do_reset();
    check("rst_x", 32'(bus.ball_x), 270);
    check("rst_y", 32'(bus.ball_y), 433);
    check("rst_in_play", 32'(bus.in_play), 0);
    check("rst_lives", 32'(bus.lives), 3);
    check("rst_over", 32'(bus.game_over), 0);
    check("rst_miss", 32'(bus.miss), 0);
    run_a(10'd238, 241);
    run_a(10'd200, MID_X);
`ifndef BALL_ANGLE_EN
    ticks(60);
    check("pre_lwall_x", 32'(bus.ball_x), 1);
    ticks(1);
    check("lwall_x", 32'(bus.ball_x), 0);
    check("lwall_y", 32'(bus.ball_y), 185);
    ticks(46);
    check("pre_top_y", 32'(bus.ball_y), 1);
    ticks(1);
    check("top_y", 32'(bus.ball_y), 0);
    check("top_x", 32'(bus.ball_x), 188);
    ticks(1);
    check("top_dy", 32'(bus.ball_y), 4);
`endif
    do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    ticks(5);
    check("play_x", 32'(bus.ball_x), 290);
    check("play_y", 32'(bus.ball_y), 413);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(1);
    check("dbl_brick_y", 32'(bus.ball_y), 409);
    ticks(1);
    check("dbl_brick_dy", 32'(bus.ball_y), 413);
    ticks(2);
    check("pre_rst_x", 32'(bus.ball_x), 306);
    do_reset();
    check("mid_rst_x", 32'(bus.ball_x), 270);
    check("mid_rst_y", 32'(bus.ball_y), 433);
    check("mid_rst_lives", 32'(bus.lives), 3);
    check("mid_rst_in_play", 32'(bus.in_play), 0);
    bus.paddle_x = 10'd900;
    ticks(1);
    check("ride_clamp_x", 32'(bus.ball_x), 633);
    run_to_miss(2);
    run_to_miss(1);
    run_to_miss(0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("over_serve_in_play", 32'(bus.in_play), 0);
    check("over_serve_over", 32'(bus.game_over), 1);
    ticks(1);
    check("over_lives", 32'(bus.lives), 0);
    check("over_miss", 32'(bus.miss), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
